// File: rtl/saph_pix_unpack_stream_if.sv
// Valid/ready bundle shared by the read DMA (word side), the pixel unpacker and the raster/blend pipeline (pixel side).
// master = the surrounding pipeline that feeds words and takes pixels; slave = the unpacker itself.
interface saph_pix_unpack_stream_if #(
    parameter int BUS_WIDTH = 32
);
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          out_col;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_col, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_col, out_valid, out_last
    );
endinterface

// File: rtl/saph_pix_unpack_stream.sv
// Streaming pixel unpacker: splits bus words of packed pixels into one ARGB8888 colour per cycle.
// Optional MSB-first pixel order is compiled in with SAPH_PIXSTREAM_MSB_FIRST_EN.
// cfg_format layout: [38:36] category (0 ARGB, 1 RGB, 2 GREY, 3 PAL), then {width[3:0], pos[4:0]}
// for a [35:27], r [26:18], g [17:9], b [8:0]; GREY takes its grey level from the b field.
module saph_pix_unpack_stream #(
    parameter int BUS_WIDTH = 32,
    parameter int MAX_BPP   = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [38:0]                  cfg_format,
    input  logic [$clog2(MAX_BPP+1)-1:0] cfg_bpp,
    input  logic [CNT_WIDTH-1:0]         cfg_count,
    input  logic                         cfg_msb_first,
    output logic                         busy,
    saph_pix_unpack_stream_if.slave      bus
);
    localparam int BPP_W  = $clog2(MAX_BPP + 1);
    localparam int IDX_W  = $clog2(BUS_WIDTH);
    localparam int LG_MAX = $clog2(MAX_BPP);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

    state_t               state, state_d;
    logic [38:0]          fmt_q;
    logic [2:0]           lg_q, lg_new;
    logic [IDX_W-1:0]     last_idx_q, idx_q;
    logic [BUS_WIDTH-1:0] word_q;
    logic [CNT_WIDTH-1:0] remaining;
    logic [31:0]          out_col_q, first_col, next_col;
    logic                 out_valid_q, out_fire, word_done, final_px;
    logic                 in_ready_c, in_fire, start_ok;

`ifdef SAPH_PIXSTREAM_MSB_FIRST_EN
    logic msb_q;
`else
    logic unused_msb;
    assign unused_msb = cfg_msb_first;
`endif

    function automatic logic [2:0] lg_of(input logic [BPP_W-1:0] b);
        logic [2:0] lg;
        case (int'(b))
            1:       lg = 3'd0;
            2:       lg = 3'd1;
            4:       lg = 3'd2;
            8:       lg = 3'd3;
            16:      lg = 3'd4;
            32:      lg = 3'd5;
            default: lg = 3'(LG_MAX);
        endcase
        if (int'(lg) > LG_MAX) lg = 3'(LG_MAX);
        return lg;
    endfunction

    // Widen a w-bit channel to 8 bits by repeating it from the MSB down
    function automatic logic [7:0] expand(input logic [7:0] v, input logic [3:0] w);
        logic [7:0] r;
        case (w)
            4'd0:    r = 8'h00;
            4'd1:    r = {8{v[0]}};
            4'd2:    r = {4{v[1:0]}};
            4'd3:    r = {v[2:0], v[2:0], v[2:1]};
            4'd4:    r = {2{v[3:0]}};
            4'd5:    r = {v[4:0], v[4:2]};
            4'd6:    r = {v[5:0], v[5:4]};
            4'd7:    r = {v[6:0], v[6]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [BUS_WIDTH-1:0] w,
                                            input logic [IDX_W-1:0] k,
                                            input logic [2:0] lg);
        logic [IDX_W-1:0] sh;
        logic [31:0]      m;
        sh = k << lg;
`ifdef SAPH_PIXSTREAM_MSB_FIRST_EN
        if (msb_q) sh = IDX_W'(BUS_WIDTH - ((int'(k) + 1) << lg));
`endif
        m = 32'((64'd1 << (32'd1 << lg)) - 64'd1);
        return 32'(w >> sh) & m;
    endfunction

    function automatic logic [31:0] color_of(input logic [31:0] px, input logic [38:0] f);
        logic [7:0]  a, r, g, b;
        logic [31:0] c;
        a = expand(8'(px >> f[31:27]), f[35:32]);
        r = expand(8'(px >> f[22:18]), f[26:23]);
        g = expand(8'(px >> f[13:9]),  f[17:14]);
        b = expand(8'(px >> f[4:0]),   f[8:5]);
        case (f[38:36])
            3'd0:    c = {a, r, g, b};
            3'd1:    c = {8'hFF, r, g, b};
            3'd2:    c = {8'hFF, 16'h0000, b};
            3'd3:    c = px;
            default: c = 32'h0;
        endcase
        return c;
    endfunction

    assign lg_new    = lg_of(cfg_bpp);
    assign start_ok  = (state == IDLE) && start && (cfg_count != '0);
    assign out_fire  = out_valid_q && bus.out_ready;
    assign word_done = (idx_q == last_idx_q);
    assign final_px  = (remaining == CNT_WIDTH'(1));
    assign in_fire   = bus.in_valid && in_ready_c;
    assign first_col = color_of(extract(bus.in_data, '0, lg_q), fmt_q);
    assign next_col  = color_of(extract(word_q, idx_q + IDX_W'(1), lg_q), fmt_q);

    assign busy          = (state != IDLE);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_col   = out_col_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_valid_q && final_px;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // A new word may enter in the same cycle the last pixel of the old one leaves, so the stream never bubbles
    always_comb begin
        state_d    = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_d = FETCH;
            end
            FETCH: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = EMIT;
            end
            EMIT: begin
                in_ready_c = out_fire && word_done && !final_px;
                if (out_fire && final_px)       state_d = IDLE;
                else if (out_fire && word_done) state_d = bus.in_valid ? EMIT : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // An accepted word goes straight to the output register; the rest of it is served from word_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q       <= '0;
            lg_q        <= '0;
            last_idx_q  <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            remaining   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef SAPH_PIXSTREAM_MSB_FIRST_EN
            msb_q       <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                fmt_q      <= cfg_format;
                lg_q       <= lg_new;
                last_idx_q <= IDX_W'((BUS_WIDTH >> lg_new) - 1);
                remaining  <= cfg_count;
`ifdef SAPH_PIXSTREAM_MSB_FIRST_EN
                msb_q      <= cfg_msb_first;
`endif
            end
            if (in_fire) begin
                word_q      <= bus.in_data;
                idx_q       <= '0;
                out_col_q   <= first_col;
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                if (word_done || final_px) begin
                    out_valid_q <= 1'b0;
                end else begin
                    idx_q     <= idx_q + IDX_W'(1);
                    out_col_q <= next_col;
                end
            end
            if (out_fire) remaining <= remaining - CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_saph_pix_unpack_stream.sv
// Directed bench for saph_pix_unpack_stream: a table of jobs with hand-computed pixels,
// plus hand-written reset, zero-count and restart-while-busy sequences.
module tb_saph_pix_unpack_stream;
    typedef struct {
        logic [38:0]       fmt;
        logic [5:0]        bpp;
        logic [15:0]       count;
        bit                msb;
        bit                toggle;
        int                restart_at;
        bit                rate;
        int                nwords;
        logic [3:0][31:0]  words;
        logic [7:0][31:0]  exp;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [38:0] cfg_format;
    logic [5:0]  cfg_bpp;
    logic [15:0] cfg_count;
    logic        cfg_msb_first;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    job_t        jobs[$];

    saph_pix_unpack_stream_if #(.BUS_WIDTH(32)) bus ();

    saph_pix_unpack_stream #(.BUS_WIDTH(32), .MAX_BPP(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_format(cfg_format),
        .cfg_bpp(cfg_bpp), .cfg_count(cfg_count), .cfg_msb_first(cfg_msb_first),
        .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] mk_fmt(input logic [2:0] cat,
                                           input logic [4:0] ap, input logic [3:0] aw,
                                           input logic [4:0] rp, input logic [3:0] rw,
                                           input logic [4:0] gp, input logic [3:0] gw,
                                           input logic [4:0] bp, input logic [3:0] bw);
        return {cat, aw, ap, rw, rp, gw, gp, bw, bp};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input job_t j, input int jn);
        int widx = 0;
        int pix = 0;
        int cyc = 0;
        int first = -1;
        int lastc = -1;
        @(negedge clk);
        cfg_format = j.fmt; cfg_bpp = j.bpp; cfg_count = j.count; cfg_msb_first = j.msb;
        start = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_output($sformatf("job%0d busy_rise", jn), 32'(busy), 32'd1);
        while (pix < int'(j.count) && cyc < 200) begin
            bus.out_ready = j.toggle ? (cyc % 2 == 0) : 1'b1;
            start = (cyc == j.restart_at);
            if (start) begin
                cfg_format = mk_fmt(3'd0, 5'd24, 4'd8, 5'd16, 4'd8, 5'd8, 4'd8, 5'd0, 4'd8);
                cfg_bpp = 6'd8; cfg_count = 16'd2;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = (widx < j.nwords) ? j.words[widx] : 32'hBAD0BAD0;
            #1;
            if (bus.in_valid && bus.in_ready) widx++;
            if (bus.out_valid) begin
                check_output($sformatf("job%0d px%0d col", jn, pix), bus.out_col, j.exp[pix]);
                check_output($sformatf("job%0d px%0d last", jn, pix), 32'(bus.out_last),
                             32'(pix == int'(j.count) - 1));
                if (bus.out_ready) begin
                    if (first < 0) first = cyc;
                    lastc = cyc;
                    pix++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_output($sformatf("job%0d pixels_seen", jn), 32'(pix), 32'(j.count));
        check_output($sformatf("job%0d busy_fall", jn), 32'(busy), 32'd0);
        check_output($sformatf("job%0d out_valid_end", jn), 32'(bus.out_valid), 32'd0);
        check_output($sformatf("job%0d in_ready_end", jn), 32'(bus.in_ready), 32'd0);
        check_output($sformatf("job%0d words_used", jn), 32'(widx), 32'(j.nwords));
        if (j.rate)
            check_output($sformatf("job%0d rate", jn), 32'(lastc - first), 32'(int'(j.count) - 1));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        job_t j;
        // ARGB8888, three words, full throughput
        j = '{default: 0};
        j.fmt = mk_fmt(3'd0, 5'd24, 4'd8, 5'd16, 4'd8, 5'd8, 4'd8, 5'd0, 4'd8);
        j.bpp = 6'd32; j.count = 16'd3; j.rate = 1'b1; j.restart_at = -1; j.nwords = 3;
        j.words[0] = 32'hFF112233; j.words[1] = 32'h80445566; j.words[2] = 32'h01020304;
        j.exp[0] = 32'hFF112233; j.exp[1] = 32'h80445566; j.exp[2] = 32'h01020304;
        jobs.push_back(j);
        // RGB565, job ends half way through the second word
        j = '{default: 0};
        j.fmt = mk_fmt(3'd1, 5'd0, 4'd0, 5'd11, 4'd5, 5'd5, 4'd6, 5'd0, 4'd5);
        j.bpp = 6'd16; j.count = 16'd3; j.restart_at = -1; j.nwords = 2;
        j.words[0] = 32'hF800001F; j.words[1] = 32'hFFFF07E0;
        j.exp[0] = 32'hFF0000FF; j.exp[1] = 32'hFFFF0000; j.exp[2] = 32'hFF00FF00;
        jobs.push_back(j);
        // PAL bpp4, out_ready toggling, a start pulse arrives mid-job
        j = '{default: 0};
        j.fmt = mk_fmt(3'd3, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0);
        j.bpp = 6'd4; j.count = 16'd8; j.toggle = 1'b1; j.restart_at = 3; j.nwords = 1;
        j.words[0] = 32'h76543210;
        for (int i = 0; i < 8; i++) j.exp[i] = 32'(i);
        jobs.push_back(j);
        // ARGB4444
        j = '{default: 0};
        j.fmt = mk_fmt(3'd0, 5'd12, 4'd4, 5'd8, 4'd4, 5'd4, 4'd4, 5'd0, 4'd4);
        j.bpp = 6'd16; j.count = 16'd2; j.restart_at = -1; j.nwords = 1;
        j.words[0] = 32'h1234F0A5;
        j.exp[0] = 32'hFF00AA55; j.exp[1] = 32'h11223344;
        jobs.push_back(j);
        // Unsupported bpp 3 falls back to 32
        j = '{default: 0};
        j.fmt = mk_fmt(3'd0, 5'd24, 4'd8, 5'd16, 4'd8, 5'd8, 4'd8, 5'd0, 4'd8);
        j.bpp = 6'd3; j.count = 16'd1; j.restart_at = -1; j.nwords = 1;
        j.words[0] = 32'hDEADBEEF; j.exp[0] = 32'hDEADBEEF;
        jobs.push_back(j);
        // Invalid category yields black
        j = '{default: 0};
        j.fmt = mk_fmt(3'd5, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd8);
        j.bpp = 6'd8; j.count = 16'd2; j.restart_at = -1; j.nwords = 1;
        j.words[0] = 32'h000000AB;
        jobs.push_back(j);
        // GREY 1bpp
        j = '{default: 0};
        j.fmt = mk_fmt(3'd2, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd1);
        j.bpp = 6'd1; j.count = 16'd3; j.restart_at = -1; j.nwords = 1;
        j.words[0] = 32'h00000005;
        j.exp[0] = 32'hFF0000FF; j.exp[1] = 32'hFF000000; j.exp[2] = 32'hFF0000FF;
        jobs.push_back(j);
        // RGB332: 3- and 2-bit channel replication
        j = '{default: 0};
        j.fmt = mk_fmt(3'd1, 5'd0, 4'd0, 5'd5, 4'd3, 5'd2, 4'd3, 5'd0, 4'd2);
        j.bpp = 6'd8; j.count = 16'd2; j.restart_at = -1; j.nwords = 1;
        j.words[0] = 32'h000049E3;
        j.exp[0] = 32'hFFFF00FF; j.exp[1] = 32'hFF494955;
        jobs.push_back(j);
`ifdef SAPH_PIXSTREAM_MSB_FIRST_EN
        j = '{default: 0};
        j.fmt = mk_fmt(3'd2, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0, 5'd0, 4'd8);
        j.bpp = 6'd8; j.count = 16'd4; j.msb = 1'b1; j.restart_at = -1; j.nwords = 1;
        j.words[0] = 32'hAABBCCDD;
        j.exp[0] = 32'hFF0000AA; j.exp[1] = 32'hFF0000BB; j.exp[2] = 32'hFF0000CC; j.exp[3] = 32'hFF0000DD;
        jobs.push_back(j);
`endif

        rst_n = 1'b0; start = 1'b0; cfg_format = '0; cfg_bpp = '0; cfg_count = '0; cfg_msb_first = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #12;
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset in_ready", 32'(bus.in_ready), 32'd0);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset out_last", 32'(bus.out_last), 32'd0);
        check_output("reset out_col", bus.out_col, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (jobs[i]) apply_stimulus(jobs[i], i);

        // Reset in the middle of a job with a pixel waiting
        @(negedge clk);
        cfg_format = jobs[0].fmt; cfg_bpp = 6'd32; cfg_count = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hFF112233; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_output("midjob out_valid", 32'(bus.out_valid), 32'd1);
        check_output("midjob out_col", bus.out_col, 32'hFF112233);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset busy", 32'(busy), 32'd0);
        check_output("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("midreset in_ready", 32'(bus.in_ready), 32'd0);
        check_output("midreset out_col", bus.out_col, 32'd0);
        rst_n = 1'b1;

        // Zero-count start must not start a job
        @(negedge clk);
        cfg_count = 16'd0; start = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_output($sformatf("count0 busy c%0d", c), 32'(busy), 32'd0);
            check_output($sformatf("count0 in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
            check_output($sformatf("count0 out_valid c%0d", c), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;

        apply_stimulus(jobs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
